// File: rtl/core_ctrl_hazard.sv
// ============================================================================
// Module  : core_ctrl_hazard
// Brief   : 5-stage pipeline control - redirect arbitration, load-use and
//           memory-wait stalls, per-stage stall/flush, perf counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module core_ctrl_hazard #(
  parameter int XLEN      = 32,
  parameter int NUM_REDIR = 2,
  parameter int CNT_W     = 32
) (
  input  logic                      clk,
  input  logic                      rst_sync,
  input  logic [NUM_REDIR-1:0]      redir_valid,
  input  logic [NUM_REDIR*XLEN-1:0] redir_addr,
  input  logic                      mem_busy,
  input  logic [4:0]                id_rs1,
  input  logic [4:0]                id_rs2,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic                      ex_is_load,
  input  logic [4:0]                ex_rd,
  input  logic                      perf_clr,
  output logic                      jump,
  output logic [XLEN-1:0]           jump_addr,
  output logic [4:0]                stall,
  output logic [4:0]                flush,
  output logic                      redir_pending,
  output logic [CNT_W-1:0]          perf_stall_cnt,
  output logic [CNT_W-1:0]          perf_flush_cnt
);

  localparam int IDX_W = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HELD = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_pend_idx;
  logic [IDX_W-1:0]  w_pend_idx_nxt;
  logic [XLEN-1:0]   r_pend_addr;
  logic [XLEN-1:0]   w_pend_addr_nxt;

  logic              w_live_any;
  logic [IDX_W-1:0]  w_live_idx;
  logic [XLEN-1:0]   w_live_addr;
  logic              w_pending;
  logic              w_hazard;
  logic              w_jump;
  logic [XLEN-1:0]   w_jump_addr;
  logic [4:0]        w_stall;
  logic [4:0]        w_flush;

  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  // Scan from the highest index down so the lowest valid index is left last.
  always_comb begin
    w_live_any  = 1'b0;
    w_live_idx  = '0;
    w_live_addr = '0;
    for (int i = NUM_REDIR - 1; i >= 0; i--) begin
      if (redir_valid[i]) begin
        w_live_any  = 1'b1;
        w_live_idx  = IDX_W'(i);
        w_live_addr = redir_addr[i*XLEN +: XLEN];
      end
    end
  end

  assign w_pending = (r_state == ST_HELD);

  assign w_hazard = ex_is_load && (ex_rd != 5'd0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  always_ff @(posedge clk or posedge rst_sync) begin
    if (rst_sync) begin
      r_state     <= ST_RUN;
      r_pend_idx  <= '0;
      r_pend_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend_idx  <= w_pend_idx_nxt;
      r_pend_addr <= w_pend_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pend_idx_nxt  = r_pend_idx;
    w_pend_addr_nxt = r_pend_addr;
    w_jump          = 1'b0;
    w_jump_addr     = '0;
    w_stall         = 5'b00000;
    w_flush         = 5'b00000;
    if (mem_busy) begin
      w_stall = 5'b11111;
      // A higher-priority live request replaces whatever is already held.
      if (w_live_any && (!w_pending || (w_live_idx < r_pend_idx))) begin
        w_state_nxt     = ST_HELD;
        w_pend_idx_nxt  = w_live_idx;
        w_pend_addr_nxt = w_live_addr;
      end
    end else if (w_pending || w_live_any) begin
      w_jump      = 1'b1;
      w_flush     = 5'b00111;
      w_state_nxt = ST_RUN;
      if (w_pending && (!w_live_any || (r_pend_idx <= w_live_idx)))
        w_jump_addr = r_pend_addr;
      else
        w_jump_addr = w_live_addr;
    end else if (w_hazard) begin
      w_stall = 5'b00011;
      w_flush = 5'b00100;
    end
  end

  always_ff @(posedge clk or posedge rst_sync) begin
    if (rst_sync) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (perf_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if ((w_stall != 5'b00000) && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_jump && (r_flush_cnt != {CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign jump           = w_jump & ~rst_sync;
  assign jump_addr      = rst_sync ? '0 : w_jump_addr;
  assign stall          = rst_sync ? 5'b00000 : w_stall;
  assign flush          = rst_sync ? 5'b00000 : w_flush;
  assign redir_pending  = w_pending;
  assign perf_stall_cnt = r_stall_cnt;
  assign perf_flush_cnt = r_flush_cnt;

endmodule

`default_nettype wire
